// File: rtl/synchronizer_if.sv
// Push-button interface: the raw button level goes in and the conditioned
// press indication comes back out.
interface synchronizer_if;
  logic push;
  logic sypush;

  modport master (
    output push,
    input  sypush
  );

  modport slave (
    input  push,
    output sypush
  );
endinterface

// File: rtl/synchronizer.sv
// Conditions one asynchronous push-button for the tug-of-war game. The chain is
// metastability flops, an optional debounce filter, then a one-shot or level output.
module synchronizer #(
  parameter int STAGES   = 2,
  parameter int DEBOUNCE = 0,
  parameter int PULSE    = 1
) (
  input logic          clk,
  input logic          rst,
  synchronizer_if.slave bus
);

  localparam int NS = (STAGES < 2) ? 2 : STAGES;
  localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

  logic [NS-1:0] s;
  logic          sync;
  logic          acc;
  logic          prev;
  logic          sypush_q;

  // NOTE: every register here uses a synchronous reset and non-blocking
  // assignments, so all flops sample their inputs from the same edge.
  always_ff @(posedge clk) begin
    if (!rst) s <= '0;
    else      s <= {s[NS-2:0], bus.push};
  end

  assign sync = s[NS-1];

  if (DEBOUNCE == 0) begin : g_nodb
    always_ff @(posedge clk) begin
      if (!rst) acc <= 1'b0;
      else      acc <= sync;
    end
  end else begin : g_db
    localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE);
    logic [CW-1:0] cnt;

    // The new level is adopted on the edge after it has already disagreed with
    // acc DEBOUNCE times, so the filter adds exactly DEBOUNCE edges of latency.
    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt <= '0;
        acc <= 1'b0;
      end else if (sync == acc) begin
        cnt <= '0;
      end else if (cnt == LIMIT) begin
        cnt <= '0;
        acc <= sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev     <= 1'b0;
      sypush_q <= 1'b0;
    end else begin
      prev     <= acc;
      sypush_q <= (PULSE != 0) ? (acc & ~prev) : acc;
    end
  end

  assign bus.sypush = sypush_q;

endmodule

// File: tb/tb_synchronizer.sv
// Scoreboarded bench: four instances (default, debounce 4, level mode, STAGES=1)
// share one push stimulus and are checked every cycle against a history-based model.
module tb_synchronizer;

  localparam int NC   = 4;
  localparam int MAXE = 4096;
  localparam int MS[NC] = '{2, 2, 2, 2};  // STAGES=1 instance behaves as 2
  localparam int MD[NC] = '{0, 4, 0, 0};
  localparam int MP[NC] = '{1, 1, 0, 1};

  typedef struct {
    bit [NC-1:0] v;
    int          n;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic push;

  always #10 clk = ~clk;

  synchronizer_if if_def ();
  synchronizer_if if_db ();
  synchronizer_if if_lvl ();
  synchronizer_if if_s1 ();

  assign if_def.push = push;
  assign if_db.push  = push;
  assign if_lvl.push = push;
  assign if_s1.push  = push;

  synchronizer #(.STAGES(2), .DEBOUNCE(0), .PULSE(1)) u_def (.clk(clk), .rst(rst), .bus(if_def));
  synchronizer #(.STAGES(2), .DEBOUNCE(4), .PULSE(1)) u_db  (.clk(clk), .rst(rst), .bus(if_db));
  synchronizer #(.STAGES(2), .DEBOUNCE(0), .PULSE(0)) u_lvl (.clk(clk), .rst(rst), .bus(if_lvl));
  synchronizer #(.STAGES(1), .DEBOUNCE(0), .PULSE(1)) u_s1  (.clk(clk), .rst(rst), .bus(if_s1));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: histories of what every edge sampled, plus the accepted level.
  bit   hp[MAXE];
  bit   hr[MAXE];
  bit   acc_h[NC][MAXE];
  int   run_c[NC];
  int   ne = 0;
  exp_t q[$];

  function automatic bit acc_at(int c, int n);
    if (n < 0) return 1'b0;
    return acc_h[c][n];
  endfunction

  // Level presented to the filter at edge n: push sampled s edges earlier,
  // provided no reset edge intervened.
  function automatic bit sync_seen(int n, int s);
    if (n - s < 0) return 1'b0;
    for (int i = n - s; i < n; i++)
      if (!hr[i]) return 1'b0;
    return hp[n - s];
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    if (ne >= MAXE) begin
      $display("FAIL edge_budget got=%0d expected=%0d", ne, MAXE - 1);
      $fatal(1, "edge history exhausted");
    end
    hp[ne] = push;
    hr[ne] = rst;
    for (int c = 0; c < NC; c++) begin
      bit l, a;
      if (!hr[ne]) begin
        acc_h[c][ne] = 1'b0;
        run_c[c]     = 0;
        e.v[c]       = 1'b0;
      end else begin
        l = sync_seen(ne, MS[c]);
        a = acc_at(c, ne - 1);
        if (MD[c] == 0)         acc_h[c][ne] = l;
        else if (l == a)        begin acc_h[c][ne] = a; run_c[c] = 0; end
        else if (run_c[c] == MD[c]) begin acc_h[c][ne] = l; run_c[c] = 0; end
        else                    begin acc_h[c][ne] = a; run_c[c]++; end
        e.v[c] = (MP[c] != 0) ? (acc_at(c, ne - 1) & ~acc_at(c, ne - 2)) : acc_at(c, ne - 1);
      end
    end
    e.n = ne;
    q.push_back(e);
    ne++;
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  // Monitor: pops one expectation per cycle and tracks output activity.
  int rise_cnt[NC];
  int rise_edge[NC];
  int high_cnt[NC];
  bit last[NC];
  bit mon_on = 1'b1;

  initial begin
    exp_t        e;
    bit [NC-1:0] act;
    for (int c = 0; c < NC; c++) begin
      rise_cnt[c] = 0; rise_edge[c] = -1; high_cnt[c] = 0; last[c] = 1'b0;
    end
    while (mon_on) begin
      @(negedge clk);
      if (q.size() != 0) begin
        e   = q.pop_front();
        act = {if_s1.sypush, if_lvl.sypush, if_db.sypush, if_def.sypush};
        for (int c = 0; c < NC; c++) begin
          check($sformatf("sypush[dut%0d]@edge%0d", c, e.n), int'(act[c]), int'(e.v[c]));
          if (act[c] === 1'b1) begin
            high_cnt[c]++;
            if (!last[c]) begin rise_cnt[c]++; rise_edge[c] = e.n; end
          end
          last[c] = (act[c] === 1'b1);
        end
      end
    end
  end

  initial begin
    int r0[NC];
    int h0;
    int n0;
    push = 1'b0;
    rst  = 1'b0;

    // Reset with push low: output stays quiet through and after release.
    tick();
    rst = 1'b1;
    idle(6);
    for (int c = 0; c < NC; c++) check($sformatf("reset_quiet[dut%0d]", c), rise_cnt[c], 0);

    // Single five-cycle press.
    r0 = rise_cnt; h0 = high_cnt[2];
    push = 1'b1; n0 = ne;
    idle(5);
    push = 1'b0;
    idle(14);
    check("single_pulses_def", rise_cnt[0] - r0[0], 1);
    check("single_latency_def", rise_edge[0] - n0, 3);
    check("single_pulse_width_def", high_cnt[0], 1);
    check("single_pulses_db", rise_cnt[1] - r0[1], 1);
    check("level_high_cycles", high_cnt[2] - h0, 5);
    check("level_latency", rise_edge[2] - n0, 3);
    check("single_latency_s1", rise_edge[3] - n0, 3);

    // Long hold: one pulse only, nothing on release.
    r0 = rise_cnt;
    push = 1'b1;
    idle(20);
    push = 1'b0;
    idle(10);
    check("long_hold_def", rise_cnt[0] - r0[0], 1);
    check("long_hold_db", rise_cnt[1] - r0[1], 1);

    // Two presses separated by three low cycles.
    r0 = rise_cnt;
    push = 1'b1; idle(5);
    push = 1'b0; idle(3);
    push = 1'b1; idle(5);
    push = 1'b0; idle(10);
    check("two_presses_def", rise_cnt[0] - r0[0], 2);

    // Reset two edges into a press; push stays high across release.
    r0 = rise_cnt;
    push = 1'b1; idle(2);
    rst = 1'b0; tick();
    rst = 1'b1; idle(10);
    push = 1'b0; idle(10);
    check("midflight_reset_def", rise_cnt[0] - r0[0], 1);
    check("midflight_reset_db", rise_cnt[1] - r0[1], 1);

    // Three-cycle glitch: rejected only by the debounced instance.
    r0 = rise_cnt;
    push = 1'b1; idle(3);
    push = 1'b0; idle(12);
    check("glitch_db", rise_cnt[1] - r0[1], 0);
    check("glitch_def", rise_cnt[0] - r0[0], 1);

    // Six-cycle press through the debounce filter.
    r0 = rise_cnt;
    push = 1'b1; n0 = ne; idle(6);
    push = 1'b0; idle(14);
    check("six_cycle_db", rise_cnt[1] - r0[1], 1);
    check("six_cycle_db_latency", rise_edge[1] - n0, 7);

    // Random press runs with occasional resets; checked only by the scoreboard.
    for (int i = 0; i < 120; i++) begin
      push = 1'($urandom_range(0, 1));
      rst  = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
      idle($urandom_range(1, 8));
      rst  = 1'b1;
    end
    push = 1'b0;
    idle(12);

    @(negedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);
    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
